// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int LAT_W  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DRIVE = 3'd2,
        WRITE    = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    // Counter preload so that the capture happens RD_LAT edges after acceptance.
    function automatic logic [LAT_W-1:0] lat_load(input int lat);
        return LAT_W'(lat - 1);
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// Processor data-port request/response signals (DATA_BUS travels separately as an inout).
interface data_mem_responder_if #(
    parameter int AW = 8
);
    logic [AW-1:0] ADDRESS;
    logic          M_read;
    logic          M_write;
    logic          mem_ready;
    logic          bus_err;

    modport master (
        output ADDRESS, M_read, M_write,
        input  mem_ready, bus_err
    );

    modport slave (
        input  ADDRESS, M_read, M_write,
        output mem_ready, bus_err
    );
endinterface

// File: rtl/data_mem_responder_array.sv
// dm_array: single-port synchronous RAM, write enable, registered read (no reset on contents).
module dm_array #(
    parameter int AW = 8,
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [WW-1:0] i_wdata,
    output logic [WW-1:0] o_rdata
);
    logic [WW-1:0] r_mem [0:(1<<AW)-1];
    logic [WW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder on the CPU data port: FSM, latency counter, tristate drive, error flags.
// Optional DATA_MEM_PARITY_EN stores an even-parity bit per word and adds sticky par_err.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus,
    inout  wire  [DW-1:0]        DATA_BUS,
`ifdef DATA_MEM_PARITY_EN
    output logic                 par_err,
`endif
    output state_t               o_dbg_state,
    output logic                 o_dbg_drive
);
`ifdef DATA_MEM_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    state_t           r_state, w_next;
    logic [AW-1:0]    r_addr;
    logic [LAT_W-1:0] r_cnt;
    logic [DW-1:0]    r_rdata;
    logic             r_bus_err;
    logic             w_accept_rd, w_accept_wr, w_both, w_capture, w_drive;
    logic [AW-1:0]    w_arr_addr;
    logic [WW-1:0]    w_wdata, w_arr_q;

    assign w_both      = bus.M_read & bus.M_write;
    assign w_accept_wr = (r_state == IDLE) & bus.M_write & ~bus.M_read;
    assign w_accept_rd = (r_state == IDLE) & bus.M_read & ~bus.M_write;
    assign w_capture   = (r_state == RD_WAIT) & bus.M_read & (r_cnt == '0);
    // In IDLE the RAM sees the live address so its registered output is ready one edge later.
    assign w_arr_addr  = (r_state == IDLE) ? bus.ADDRESS : r_addr;

`ifdef DATA_MEM_PARITY_EN
    assign w_wdata = {^DATA_BUS, DATA_BUS};
`else
    assign w_wdata = DATA_BUS;
`endif

    dm_array #(.AW(AW), .WW(WW)) u_array (
        .clk     (clk),
        .i_we    (w_accept_wr),
        .i_addr  (w_arr_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_q)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept_wr)      w_next = WRITE;
                else if (w_accept_rd) w_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (!bus.M_read)        w_next = IDLE;
                else if (r_cnt == '0)   w_next = RD_DRIVE;
            end
            RD_DRIVE: begin
                if (!bus.M_read) w_next = IDLE;
            end
            WRITE:    w_next = WAIT_REL;
            WAIT_REL: begin
                if (!bus.M_read && !bus.M_write) w_next = IDLE;
            end
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept_rd) begin
                r_addr <= bus.ADDRESS;
                r_cnt  <= lat_load(RD_LAT);
            end else if (r_state == RD_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rdata <= w_arr_q[DW-1:0];
            end
            if (r_state == IDLE && w_both) begin
                r_bus_err <= 1'b1;
            end
        end
    end

`ifdef DATA_MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (w_capture && (^w_arr_q)) begin
            par_err <= 1'b1;
        end
    end
`endif

    // Drive is gated by M_read directly so the bus frees in the cycle M_read falls.
    assign w_drive       = (r_state == RD_DRIVE) & bus.M_read;
    assign DATA_BUS      = w_drive ? r_rdata : {DW{1'bz}};
    assign bus.mem_ready = (r_state == WRITE) | (r_state == RD_DRIVE);
    assign bus.bus_err   = r_bus_err;
    assign o_dbg_state   = r_state;
    assign o_dbg_drive   = w_drive;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder: one instance with RD_LAT=1, one with RD_LAT=4.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.AW(8)) if1 ();
    data_mem_responder_if #(.AW(8)) if4 ();

    wire  [7:0] bus1, bus4;
    logic [7:0] drv1 = 8'h00, drv4 = 8'h00;
    logic       oe1 = 1'b0, oe4 = 1'b0;
    assign bus1 = oe1 ? drv1 : 8'hzz;
    assign bus4 = oe4 ? drv4 : 8'hzz;

    state_t st1, st4;
    logic   dr1, dr4;
`ifdef DATA_MEM_PARITY_EN
    logic   pe1, pe4;
`endif

    data_mem_responder #(.AW(8), .DW(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .DATA_BUS(bus1),
`ifdef DATA_MEM_PARITY_EN
        .par_err(pe1),
`endif
        .o_dbg_state(st1), .o_dbg_drive(dr1)
    );

    data_mem_responder #(.AW(8), .DW(8), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .DATA_BUS(bus4),
`ifdef DATA_MEM_PARITY_EN
        .par_err(pe4),
`endif
        .o_dbg_state(st4), .o_dbg_drive(dr4)
    );

    // Reference model: memory image, written flags, sticky error and latency per instance.
    logic [7:0] mem_m [2][256];
    bit         wr_m  [2][256];
    logic [7:0] wq    [2][$];
    logic       err_m [2];
    int checks = 0;
    int failures = 0;

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    function automatic logic o_ready(input int s);
        return (s == 0) ? if1.mem_ready : if4.mem_ready;
    endfunction
    function automatic logic o_err(input int s);
        return (s == 0) ? if1.bus_err : if4.bus_err;
    endfunction
    function automatic logic o_drive(input int s);
        return (s == 0) ? dr1 : dr4;
    endfunction
    function automatic logic [7:0] o_data(input int s);
        return (s == 0) ? bus1 : bus4;
    endfunction
    function automatic logic [2:0] o_state(input int s);
        return (s == 0) ? st1 : st4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int s, input logic rd, input logic wr, input logic [7:0] a);
        if (s == 0) begin
            if1.M_read = rd; if1.M_write = wr; if1.ADDRESS = a;
        end else begin
            if4.M_read = rd; if4.M_write = wr; if4.ADDRESS = a;
        end
    endtask

    task automatic set_drv(input int s, input logic oe, input logic [7:0] d);
        if (s == 0) begin oe1 = oe; drv1 = d; end
        else begin oe4 = oe; drv4 = d; end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input int s, input logic [7:0] a, input logic [7:0] d);
        set_req(s, 1'b0, 1'b1, a);
        set_drv(s, 1'b1, d);
        @(posedge clk); #1;
        check("wr_ready", 32'(o_ready(s)), 32'd1);
        check("wr_state", 32'(o_state(s)), 32'(WRITE));
        set_req(s, 1'b0, 1'b0, 8'($urandom));
        set_drv(s, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("wr_ready_low", 32'(o_ready(s)), 32'd0);
        @(posedge clk); #1;
        mem_m[s][a] = d;
        if (!wr_m[s][a]) wq[s].push_back(a);
        wr_m[s][a] = 1'b1;
    endtask

    task automatic do_read(input int s, input logic [7:0] a);
        int n;
        bit got;
        n = 0;
        got = 0;
        set_req(s, 1'b1, 1'b0, a);
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) set_req(s, 1'b1, 1'b0, 8'($urandom));
            if (o_ready(s)) got = 1;
        end
        check("rd_latency", 32'(n), 32'(lat_of(s) + 1));
        check("rd_drive", 32'(o_drive(s)), 32'd1);
        check("rd_data", 32'(o_data(s)), 32'(mem_m[s][a]));
        set_req(s, 1'b0, 1'b0, 8'($urandom));
        #1;
        check("rd_release", 32'(o_drive(s)), 32'd0);
        @(posedge clk); #1;
        check("rd_idle", 32'(o_state(s)), 32'(IDLE));
        check("rd_bus_err", 32'(o_err(s)), 32'(err_m[s]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 1'b0, 1'b0, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00);
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) begin
            wr_m[s][i] = 1'b0; mem_m[s][i] = 8'h00;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(o_ready(s)), 32'd0);
            check("rst_bus_err", 32'(o_err(s)), 32'd0);
            check("rst_drive", 32'(o_drive(s)), 32'd0);
            check("rst_state", 32'(o_state(s)), 32'(IDLE));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic store/load with RD_LAT=1.
        do_write(0, 8'h3C, 8'hA5);
        do_read(0, 8'h3C);

        // Conflicting request: error flag, no access, bus untouched.
        do_write(0, 8'h10, 8'h33);
        set_req(0, 1'b1, 1'b1, 8'h10);
        @(posedge clk); #1;
        err_m[0] = 1'b1;
        check("both_bus_err", 32'(if1.bus_err), 32'd1);
        check("both_state", 32'(st1), 32'(IDLE));
        check("both_drive", 32'(dr1), 32'd0);
        check("both_ready", 32'(if1.mem_ready), 32'd0);
        set_req(0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        do_read(0, 8'h10);

        // Aborted read on the RD_LAT=4 instance, then a normal read.
        do_write(1, 8'h40, 8'hC3);
        set_req(1, 1'b1, 1'b0, 8'h40);
        repeat (2) begin @(posedge clk); #1; end
        set_req(1, 1'b0, 1'b0, 8'h40);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_ready", 32'(if4.mem_ready), 32'd0);
            check("abort_drive", 32'(dr4), 32'd0);
        end
        check("abort_state", 32'(st4), 32'(IDLE));
        do_read(1, 8'h40);

        // Address extremes on both instances.
        for (int s = 0; s < 2; s++) begin
            do_write(s, 8'hFF, 8'hFF);
            do_read(s, 8'hFF);
            do_write(s, 8'h00, 8'h01);
            do_read(s, 8'h00);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 40; k++) begin
            int s;
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                do_write(s, 8'($urandom), 8'($urandom));
            end else begin
                do_read(s, wq[s][$urandom_range(0, wq[s].size() - 1)]);
            end
        end

        // Reset in the middle of a read drive.
        set_req(0, 1'b1, 1'b0, 8'h3C);
        repeat (2) begin @(posedge clk); #1; end
        check("mid_drive_before", 32'(dr1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_drive", 32'(dr1), 32'd0);
        check("mid_rst_ready", 32'(if1.mem_ready), 32'd0);
        check("mid_rst_bus_err", 32'(if1.bus_err), 32'd0);
        check("mid_rst_state", 32'(st1), 32'(IDLE));
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(0, 8'h3C);
        do_read(1, 8'h40);

`ifdef DATA_MEM_PARITY_EN
        check("par_clear", 32'(pe1), 32'd0);
        do_write(0, 8'h20, 8'h5A);
        u_dut1.u_array.r_mem[32] = u_dut1.u_array.r_mem[32] ^ 9'h001;
        mem_m[0][8'h20] = 8'h5B;
        do_read(0, 8'h20);
        check("par_err", 32'(pe1), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
